// File: rtl/video_timing_pkg.sv
// Shared timing constants, counter width and colour-bar palette for the raster generator.
package video_timing_pkg;

   localparam int CNT_W = 12;

   // 1280x720p60
   localparam int H720_ACTIVE = 1280;
   localparam int H720_FP     = 110;
   localparam int H720_SYNC   = 40;
   localparam int H720_BP     = 220;
   localparam int V720_ACTIVE = 720;
   localparam int V720_FP     = 5;
   localparam int V720_SYNC   = 5;
   localparam int V720_BP     = 20;

   // 640x480p60
   localparam int H480_ACTIVE = 640;
   localparam int H480_FP     = 16;
   localparam int H480_SYNC   = 96;
   localparam int H480_BP     = 48;
   localparam int V480_ACTIVE = 480;
   localparam int V480_FP     = 10;
   localparam int V480_SYNC   = 2;
   localparam int V480_BP     = 33;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Polarity-free sync flags travelling down the pipeline beside the pixel.
   typedef struct packed {
      logic fs;
      logic vs;
      logic hs;
      logic de;
   } sync_t;

   localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
   localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
   localparam rgb_t RGB_CYAN    = 24'h00FFFF;
   localparam rgb_t RGB_GREEN   = 24'h00FF00;
   localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
   localparam rgb_t RGB_RED     = 24'hFF0000;
   localparam rgb_t RGB_BLUE    = 24'h0000FF;
   localparam rgb_t RGB_BLACK   = 24'h000000;

   function automatic rgb_t bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return RGB_WHITE;
         3'd1:    return RGB_YELLOW;
         3'd2:    return RGB_CYAN;
         3'd3:    return RGB_GREEN;
         3'd4:    return RGB_MAGENTA;
         3'd5:    return RGB_RED;
         3'd6:    return RGB_BLUE;
         default: return RGB_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-fetch and DVI-side signal bundle; master is the timing generator, slave the source/transmitter side.
interface video_timing_gen_if;
   import video_timing_pkg::*;

   logic       O_pix_req;
   cnt_t       O_pix_x;
   cnt_t       O_pix_y;
   logic [7:0] I_pix_r;
   logic [7:0] I_pix_g;
   logic [7:0] I_pix_b;
   logic       O_rgb_vs;
   logic       O_rgb_hs;
   logic       O_rgb_de;
   logic [7:0] O_rgb_r;
   logic [7:0] O_rgb_g;
   logic [7:0] O_rgb_b;
   logic       O_frame_start;

   modport master (
      output O_pix_req, O_pix_x, O_pix_y,
      input  I_pix_r, I_pix_g, I_pix_b,
      output O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b, O_frame_start
   );

   modport slave (
      input  O_pix_req, O_pix_x, O_pix_y,
      output I_pix_r, I_pix_g, I_pix_b,
      input  O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b, O_frame_start
   );

endinterface

// File: rtl/video_colorbar.sv
// Combinational column-to-colour map for the eight-bar test pattern (white .. black, left to right).
module video_colorbar
   import video_timing_pkg::*;
#(
   parameter int BAR_W = 160
) (
   input  cnt_t x,
   output rgb_t rgb
);

   cnt_t       bar_q;
   logic [2:0] bar_idx;

   always_comb begin
      bar_q   = x / cnt_t'(BAR_W);
      // Columns past the eighth bar (H_ACTIVE not divisible by 8) stay black.
      bar_idx = (bar_q > cnt_t'(7)) ? 3'd7 : bar_q[2:0];
      rgb     = bar_color(bar_idx);
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster generator: h/v counters, pixel fetch strobe, and 2-clock aligned DVI sync/RGB outputs.
// Build option VIDEO_TIMING_GEN_COLORBAR_EN replaces fetched pixels with an eight-bar pattern.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = H720_ACTIVE,
   parameter int H_FP     = H720_FP,
   parameter int H_SYNC   = H720_SYNC,
   parameter int H_BP     = H720_BP,
   parameter int V_ACTIVE = V720_ACTIVE,
   parameter int V_FP     = V720_FP,
   parameter int V_SYNC   = V720_SYNC,
   parameter int V_BP     = V720_BP,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input logic                I_rgb_clk,
   input logic                I_rst,
   input logic                I_en,
   video_timing_gen_if.master vid
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   cnt_t  h_cnt_reg, v_cnt_reg;
   logic  h_last, v_last;
   sync_t flags_next;
   sync_t s1_reg, s2_reg, s3_reg;
   cnt_t  pix_x_reg, pix_y_reg;
   rgb_t  rgb_next, rgb_reg;

   assign h_last = (h_cnt_reg == cnt_t'(H_TOTAL - 1));
   assign v_last = (v_cnt_reg == cnt_t'(V_TOTAL - 1));

   always_ff @(posedge I_rgb_clk) begin
      if (I_rst || !I_en) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         h_cnt_reg <= h_last ? '0 : h_cnt_reg + cnt_t'(1);
         if (h_last) begin
            v_cnt_reg <= v_last ? '0 : v_cnt_reg + cnt_t'(1);
         end
      end
   end

   // With I_en low the counters sit at (0,0), which would decode as active; gate everything.
   always_comb begin
      flags_next = '0;
      if (I_en) begin
         flags_next.de = (h_cnt_reg < cnt_t'(H_ACTIVE)) && (v_cnt_reg < cnt_t'(V_ACTIVE));
         flags_next.hs = (h_cnt_reg >= cnt_t'(HS_START)) && (h_cnt_reg < cnt_t'(HS_END));
         flags_next.vs = (v_cnt_reg >= cnt_t'(VS_START)) && (v_cnt_reg < cnt_t'(VS_END));
         flags_next.fs = (h_cnt_reg == '0) && (v_cnt_reg == '0);
      end
   end

   always_ff @(posedge I_rgb_clk) begin
      if (I_rst) begin
         s1_reg    <= '0;
         s2_reg    <= '0;
         s3_reg    <= '0;
         pix_x_reg <= '0;
         pix_y_reg <= '0;
         rgb_reg   <= '0;
      end else begin
         s1_reg  <= flags_next;
         s2_reg  <= s1_reg;
         s3_reg  <= s2_reg;
         rgb_reg <= rgb_next;
         if (flags_next.de) begin
            pix_x_reg <= h_cnt_reg;
            pix_y_reg <= v_cnt_reg;
         end
      end
   end

`ifdef VIDEO_TIMING_GEN_COLORBAR_EN
   // x delayed one more clock so the bar colour lines up with where the fetched pixel would land.
   cnt_t pix_x_mid_reg;
   rgb_t bar_rgb;

   always_ff @(posedge I_rgb_clk) begin
      if (I_rst) begin
         pix_x_mid_reg <= '0;
      end else begin
         pix_x_mid_reg <= pix_x_reg;
      end
   end

   video_colorbar #(.BAR_W(H_ACTIVE / 8)) u_colorbar (
      .x   (pix_x_mid_reg),
      .rgb (bar_rgb)
   );

   assign rgb_next = s2_reg.de ? bar_rgb : '0;
`else
   assign rgb_next = s2_reg.de ? rgb_t'({vid.I_pix_r, vid.I_pix_g, vid.I_pix_b}) : '0;
`endif

   assign vid.O_pix_req     = s1_reg.de;
   assign vid.O_pix_x       = pix_x_reg;
   assign vid.O_pix_y       = pix_y_reg;
   assign vid.O_rgb_de      = s3_reg.de;
   assign vid.O_rgb_hs      = s3_reg.hs ? HS_POL : ~HS_POL;
   assign vid.O_rgb_vs      = s3_reg.vs ? VS_POL : ~VS_POL;
   assign vid.O_frame_start = s3_reg.fs;
   assign vid.O_rgb_r       = rgb_reg.r;
   assign vid.O_rgb_g       = rgb_reg.g;
   assign vid.O_rgb_b       = rgb_reg.b;

endmodule
